// File: rtl/icache_mem_responder_pkg.sv
// Shared icache constants and the memory-responder FSM state type.
// Common to the cache and its backing-memory responder.
package icache_mem_responder_pkg;

  localparam int unsigned ICACHE_ADDR_WIDTH        = 16;
  localparam int unsigned ICACHE_WORD_WIDTH        = 20;
  localparam int unsigned ICACHE_MEM_IF_DATA_WIDTH = 128;
  localparam int unsigned BEATS_PER_BLOCK          = 4;
  localparam int unsigned LANE_WIDTH               = 32;
  localparam int unsigned BLOCK_OFFSET_BITS        = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST
  } resp_state_e;

endpackage

// File: rtl/icache_mem_responder_if.sv
// Block-fill request / beat-response bus between the icache and its memory responder.
interface icache_mem_responder_if
  import icache_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ICACHE_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ICACHE_MEM_IF_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] i_mem_addr;
  logic                  i_mem_req_valid;
  logic                  o_mem_ready;
  logic [DATA_WIDTH-1:0] o_mem_data;
  logic                  o_mem_data_valid;
  logic                  o_mem_data_last;

  modport master (
    output i_mem_addr,
    output i_mem_req_valid,
    input  o_mem_ready,
    input  o_mem_data,
    input  o_mem_data_valid,
    input  o_mem_data_last
  );

  modport slave (
    input  i_mem_addr,
    input  i_mem_req_valid,
    output o_mem_ready,
    output o_mem_data,
    output o_mem_data_valid,
    output o_mem_data_last
  );

endinterface

// File: rtl/icache_backing_store.sv
// Word-addressed backing memory: one synchronous write port, one aligned
// multi-word combinational read port. Contents survive reset.
module icache_backing_store #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned WORD_WIDTH = 20,
  parameter int unsigned READ_WORDS = 4
) (
  input  logic                                  clk,
  input  logic                                  wr_en,
  input  logic [ADDR_WIDTH-1:0]                 wr_addr,
  input  logic [WORD_WIDTH-1:0]                 wr_data,
  input  logic [ADDR_WIDTH-$clog2(READ_WORDS)-1:0] rd_group,
  output logic [READ_WORDS-1:0][WORD_WIDTH-1:0] rd_words
);

  localparam int unsigned SEL_W = $clog2(READ_WORDS);

  logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_words = '0;
    for (int unsigned j = 0; j < READ_WORDS; j++) begin
      rd_words[j] = mem[{rd_group, SEL_W'(j)}];
    end
  end

endmodule

// File: rtl/icache_mem_responder.sv
// Behavioural memory responder for icache block fills: accepts one aligned
// 16-word request, waits LATENCY cycles, then streams four 4-lane beats.
module icache_mem_responder
  import icache_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH        = ICACHE_ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH        = ICACHE_WORD_WIDTH,
  parameter int unsigned MEM_IF_DATA_WIDTH = ICACHE_MEM_IF_DATA_WIDTH,
  parameter int unsigned LATENCY           = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_halt,
  icache_mem_responder_if.slave mem,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic [WORD_WIDTH-1:0] i_load_data,
  input  logic                  i_load_valid
);

  localparam int unsigned WORDS_PER_BEAT = MEM_IF_DATA_WIDTH / LANE_WIDTH;
  localparam int unsigned BEAT_W         = $clog2(BEATS_PER_BLOCK);
  localparam int unsigned BLK_W          = ADDR_WIDTH - BLOCK_OFFSET_BITS;
  localparam logic [3:0]  WAIT_LOAD      = (LATENCY > 1) ? 4'(LATENCY - 2) : '0;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_BLOCK - 1);

  resp_state_e       state;
  logic [3:0]        wait_cnt;
  logic [BEAT_W-1:0] beat;
  logic [BLK_W-1:0]  blk_addr;

  logic                                      beat_valid;
  logic [WORDS_PER_BEAT-1:0][WORD_WIDTH-1:0] rd_words;

  // Offset bits are deliberately dropped: fills are always block aligned.
  logic [BLOCK_OFFSET_BITS-1:0] unused_offset;
  assign unused_offset = mem.i_mem_addr[BLOCK_OFFSET_BITS-1:0];

  icache_backing_store #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_WIDTH (WORD_WIDTH),
    .READ_WORDS (WORDS_PER_BEAT)
  ) u_store (
    .clk      (clk),
    .wr_en    (i_load_valid),
    .wr_addr  (i_load_addr),
    .wr_data  (i_load_data),
    .rd_group ({blk_addr, beat}),
    .rd_words (rd_words)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      beat     <= '0;
      blk_addr <= '0;
    end else if (!i_halt) begin
      case (state)
        ST_IDLE: begin
          if (mem.i_mem_req_valid) begin
            blk_addr <= mem.i_mem_addr[ADDR_WIDTH-1:BLOCK_OFFSET_BITS];
            beat     <= '0;
            if (LATENCY > 1) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= ST_BURST;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state <= ST_BURST;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_BURST: begin
          if (beat == LAST_BEAT) begin
            state <= ST_IDLE;
            beat  <= '0;
          end else begin
            beat <= beat + BEAT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Beats are read in the cycle they are presented, so halt simply masks them.
  assign beat_valid           = (state == ST_BURST) && !i_halt;
  assign mem.o_mem_ready      = (state == ST_IDLE) && !i_halt && arst_n;
  assign mem.o_mem_data_valid = beat_valid;
  assign mem.o_mem_data_last  = beat_valid && (beat == LAST_BEAT);

  always_comb begin
    mem.o_mem_data = '0;
    if (beat_valid) begin
      for (int unsigned j = 0; j < WORDS_PER_BEAT; j++) begin
        mem.o_mem_data[j*LANE_WIDTH +: LANE_WIDTH] = LANE_WIDTH'(rd_words[j]);
      end
    end
  end

endmodule
